// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU result checker: run states,
// comparison classes and the one-ULP rounding tolerance.
package fpu_pkg;

  localparam int unsigned FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] ROUND_TOL = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_MATCH    = 2'd0,
    CLS_ROUND    = 2'd1,
    CLS_MISMATCH = 2'd2
  } cls_e;

  // Bit patterns one ULP apart in either direction count as rounding noise.
  function automatic cls_e classify(input logic [FLOAT_W-1:0] res,
                                    input logic [FLOAT_W-1:0] exp_v);
    logic [FLOAT_W-1:0] diff;
    diff = res - exp_v;
    if (diff == '0)
      return CLS_MATCH;
    else if (diff == ROUND_TOL || diff == -ROUND_TOL)
      return CLS_ROUND;
    else
      return CLS_MISMATCH;
  endfunction

endpackage

// File: rtl/fpu_result_checker_if.sv
// Stimulus/result bundle between an FPU test harness and the result checker.
interface fpu_result_checker_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic                          Start;
  logic                          ExpValid;
  logic [fpu_pkg::FLOAT_W-1:0]   ExpData;
  logic                          ExpReady;
  logic                          ResValid;
  logic [fpu_pkg::FLOAT_W-1:0]   Result;
  logic                          Busy;
  logic                          Done;
  logic [CNT_W-1:0]              MatchCount;
  logic [CNT_W-1:0]              RoundCount;
  logic [CNT_W-1:0]              MismatchCount;
  logic [CNT_W-1:0]              FirstBadIndex;
  logic [fpu_pkg::FLOAT_W-1:0]   FirstBadResult;
  logic [fpu_pkg::FLOAT_W-1:0]   FirstBadExpected;
  logic                          BadSeen;
  logic                          Underflow;

  modport master (
    output Start, ExpValid, ExpData, ResValid, Result,
    input  ExpReady, Busy, Done, MatchCount, RoundCount, MismatchCount,
           FirstBadIndex, FirstBadResult, FirstBadExpected, BadSeen, Underflow
  );

  modport slave (
    input  Start, ExpValid, ExpData, ResValid, Result,
    output ExpReady, Busy, Done, MatchCount, RoundCount, MismatchCount,
           FirstBadIndex, FirstBadResult, FirstBadExpected, BadSeen, Underflow
  );

endinterface

// File: rtl/fpu_exp_fifo.sv
// Synchronous FIFO of expected results; a pop in the same cycle frees a slot
// for a push even when full. Flush empties it in one cycle.
module fpu_exp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_result_checker.sv
// Compares a stream of FPU results against queued expected values, tallying
// exact matches, one-ULP rounding differences and mismatches per run.
module fpu_result_checker
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_VECTORS = 500,
  parameter int unsigned CNT_W       = 16
) (
  input logic                  CLK,
  input logic                  RST,
  fpu_result_checker_if.slave  bus
);

  localparam int unsigned FCW = $clog2(DEPTH) + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     match_q, match_d;
  logic [CNT_W-1:0]     round_q, round_d;
  logic [CNT_W-1:0]     mis_q, mis_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     bad_idx_q, bad_idx_d;
  logic [FLOAT_W-1:0]   bad_res_q, bad_res_d;
  logic [FLOAT_W-1:0]   bad_exp_q, bad_exp_d;
  logic                 bad_seen_q, bad_seen_d;
  logic                 uflow_q, uflow_d;

  logic                 fifo_full, fifo_empty;
  logic [FLOAT_W-1:0]   fifo_head;
  logic [FCW-1:0]       fifo_count;

  logic                 run, push, take_res, pop, uflow_evt, quota_left;
  cls_e                 cls;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign run        = (state_q == ST_RUN);
  assign quota_left = (idx_q < CNT_W'(NUM_VECTORS));
  assign push       = run && !bus.Start && bus.ExpValid && !fifo_full;
  // Results past the quota (the single cycle before DONE) are dropped.
  assign take_res   = run && !bus.Start && bus.ResValid && quota_left;
  assign pop        = take_res && !fifo_empty;
  assign uflow_evt  = take_res && fifo_empty;
  assign cls        = classify(bus.Result, fifo_head);

  fpu_exp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLOAT_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (bus.Start),
    .push_i  (push),
    .data_i  (bus.ExpData),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    assert (fifo_count <= FCW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    if (bus.Start)
      state_d = ST_RUN;
    else if (run && !quota_left)
      state_d = ST_DONE;
  end

  always_comb begin
    match_d    = match_q;
    round_d    = round_q;
    mis_d      = mis_q;
    idx_d      = idx_q;
    bad_idx_d  = bad_idx_q;
    bad_res_d  = bad_res_q;
    bad_exp_d  = bad_exp_q;
    bad_seen_d = bad_seen_q;
    uflow_d    = uflow_q;
    if (bus.Start) begin
      match_d    = '0;
      round_d    = '0;
      mis_d      = '0;
      idx_d      = '0;
      bad_idx_d  = '0;
      bad_res_d  = '0;
      bad_exp_d  = '0;
      bad_seen_d = 1'b0;
      uflow_d    = 1'b0;
    end else begin
      if (uflow_evt) uflow_d = 1'b1;
      if (pop) begin
        idx_d = sat_inc(idx_q);
        case (cls)
          CLS_MATCH: match_d = sat_inc(match_q);
          CLS_ROUND: round_d = sat_inc(round_q);
          default: begin
            mis_d = sat_inc(mis_q);
            if (!bad_seen_q) begin
              bad_seen_d = 1'b1;
              bad_idx_d  = idx_q;
              bad_res_d  = bus.Result;
              bad_exp_d  = fifo_head;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      match_q    <= '0;
      round_q    <= '0;
      mis_q      <= '0;
      idx_q      <= '0;
      bad_idx_q  <= '0;
      bad_res_q  <= '0;
      bad_exp_q  <= '0;
      bad_seen_q <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      round_q    <= round_d;
      mis_q      <= mis_d;
      idx_q      <= idx_d;
      bad_idx_q  <= bad_idx_d;
      bad_res_q  <= bad_res_d;
      bad_exp_q  <= bad_exp_d;
      bad_seen_q <= bad_seen_d;
      uflow_q    <= uflow_d;
    end
  end

  assign bus.ExpReady         = run && !fifo_full;
  assign bus.Busy             = run;
  assign bus.Done             = (state_q == ST_DONE);
  assign bus.MatchCount       = match_q;
  assign bus.RoundCount       = round_q;
  assign bus.MismatchCount    = mis_q;
  assign bus.FirstBadIndex    = bad_idx_q;
  assign bus.FirstBadResult   = bad_res_q;
  assign bus.FirstBadExpected = bad_exp_q;
  assign bus.BadSeen          = bad_seen_q;
  assign bus.Underflow        = uflow_q;

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker: a queue-based reference model is
// checked against every output on each falling edge, plus literal spot checks.
module tb_fpu_result_checker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NV    = 500;
  localparam int unsigned CW    = 16;
  localparam int          CMAX  = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  fpu_result_checker_if #(.CNT_W(CW)) bus ();

  fpu_result_checker #(
    .DEPTH       (DEPTH),
    .NUM_VECTORS (NV),
    .CNT_W       (CW)
  ) dut (
    .CLK (CLK),
    .RST (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model
  logic [31:0] mq[$];
  bit          m_run = 0, m_done = 0, m_bad_seen = 0, m_uflow = 0;
  int          m_ncmp = 0, m_match = 0, m_round = 0, m_mis = 0, m_bad_idx = 0;
  logic [31:0] m_bad_res = '0, m_bad_exp = '0;

  function automatic logic [31:0] sat(input int v);
    return 32'((v > CMAX) ? CMAX : v);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ncmp = 0; m_match = 0; m_round = 0; m_mis = 0; m_bad_idx = 0;
    m_bad_res = '0; m_bad_exp = '0; m_bad_seen = 0; m_uflow = 0;
  endtask

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      model_clear();
      m_run = 0; m_done = 0;
    end else if (bus.Start) begin
      model_clear();
      m_run = 1; m_done = 0;
    end else if (m_run) begin
      if (m_ncmp == NV) begin
        m_run = 0; m_done = 1;
      end else begin
        bit          room;
        logic [31:0] h, d;
        room = (mq.size() < DEPTH);
        if (bus.ResValid) begin
          if (mq.size() == 0) m_uflow = 1;
          else begin
            h = mq.pop_front();
            d = bus.Result - h;
            if (d == 0) m_match++;
            else if (d == 32'h1 || d == 32'hFFFF_FFFF) m_round++;
            else begin
              if (!m_bad_seen) begin
                m_bad_seen = 1; m_bad_idx = m_ncmp;
                m_bad_res = bus.Result; m_bad_exp = h;
              end
              m_mis++;
            end
            m_ncmp++;
          end
        end
        if (bus.ExpValid && room) mq.push_back(bus.ExpData);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("busy",      32'(bus.Busy),      32'(m_run));
    chk("done",      32'(bus.Done),      32'(m_done));
    chk("expready",  32'(bus.ExpReady),  32'(m_run && mq.size() < DEPTH));
    chk("match",     32'(bus.MatchCount),    sat(m_match));
    chk("round",     32'(bus.RoundCount),    sat(m_round));
    chk("mismatch",  32'(bus.MismatchCount), sat(m_mis));
    chk("badidx",    32'(bus.FirstBadIndex), sat(m_bad_idx));
    chk("badres",    bus.FirstBadResult,     m_bad_res);
    chk("badexp",    bus.FirstBadExpected,   m_bad_exp);
    chk("badseen",   32'(bus.BadSeen),   32'(m_bad_seen));
    chk("underflow", 32'(bus.Underflow), 32'(m_uflow));
  end

  // Stimulus
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    bus.ExpValid = 1'b1; bus.ExpData = v; tick(); bus.ExpValid = 1'b0;
  endtask

  task automatic result(input logic [31:0] r);
    bus.ResValid = 1'b1; bus.Result = r; tick(); bus.ResValid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.Busy), 0);
    chk({tag, "_done"},  32'(bus.Done), 0);
    chk({tag, "_rdy"},   32'(bus.ExpReady), 0);
    chk({tag, "_cnts"},  32'(bus.MatchCount | bus.RoundCount | bus.MismatchCount | bus.FirstBadIndex), 0);
    chk({tag, "_caps"},  bus.FirstBadResult | bus.FirstBadExpected, 0);
    chk({tag, "_flags"}, 32'({bus.BadSeen, bus.Underflow}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v [NV];
    bus.Start = 0; bus.ExpValid = 0; bus.ExpData = '0;
    bus.ResValid = 0; bus.Result = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Inputs outside a run are ignored
    bus.ExpValid = 1; bus.ResValid = 1; tick(); bus.ExpValid = 0; bus.ResValid = 0;
    chk("idle_ignore_uflow", 32'(bus.Underflow), 0);

    // Exact match
    do_start();
    chk("start_busy", 32'(bus.Busy), 1);
    push(32'h3F80_0000);
    result(32'h3F80_0000);
    chk("t37_match", 32'(bus.MatchCount), 1);
    chk("t37_other", 32'(bus.RoundCount + bus.MismatchCount), 0);

    // One-ULP differences either way
    do_start();
    push(32'h4049_0FDB); result(32'h4049_0FDC);
    push(32'h4049_0FDB); result(32'h4049_0FDA);
    chk("t38_round", 32'(bus.RoundCount), 2);
    chk("t38_mis",   32'(bus.MismatchCount), 0);

    // First mismatch capture
    do_start();
    push(32'h3F80_0000); push(32'h4000_0000);
    result(32'h3F80_0000); result(32'h4040_0000);
    push(32'h1234_5678); result(32'h0000_0000);
    chk("t39_mis",     32'(bus.MismatchCount), 2);
    chk("t39_idx",     32'(bus.FirstBadIndex), 1);
    chk("t39_res",     bus.FirstBadResult, 32'h4040_0000);
    chk("t39_exp",     bus.FirstBadExpected, 32'h4000_0000);
    chk("t39_badseen", 32'(bus.BadSeen), 1);

    // Full FIFO, pop with push held
    do_start();
    for (int i = 0; i < DEPTH; i++) push(32'h4100_0000 + 32'(i));
    chk("t40_full_rdy", 32'(bus.ExpReady), 0);
    bus.ExpValid = 1; bus.ExpData = 32'h4120_0000;
    bus.ResValid = 1; bus.Result = 32'h4100_0000;
    tick(); bus.ResValid = 0;
    chk("t40_slot_rdy", 32'(bus.ExpReady), 1);
    tick(); bus.ExpValid = 0;
    chk("t40_refull_rdy", 32'(bus.ExpReady), 0);
    for (int i = 1; i < DEPTH; i++) result(32'h4100_0000 + 32'(i));
    result(32'h4120_0000);
    chk("t40_match", 32'(bus.MatchCount), 9);
    chk("t40_mis",   32'(bus.MismatchCount), 0);

    // Underflow, push+pop on empty, then reset mid-run
    do_start();
    result(32'h0000_0001);
    chk("t41_uflow", 32'(bus.Underflow), 1);
    chk("t41_cnt",   32'(bus.MatchCount | bus.MismatchCount | bus.RoundCount), 0);
    bus.ExpValid = 1; bus.ExpData = 32'hC0A0_0000;
    bus.ResValid = 1; bus.Result = 32'hC0A0_0000;
    tick(); bus.ExpValid = 0; bus.ResValid = 0;
    chk("t41_nobypass", 32'(bus.MatchCount), 0);
    result(32'hC0A0_0000);
    chk("t41_stored", 32'(bus.MatchCount), 1);
    push(32'h1111_1111);
    #2 rst = 1'b1;
    #1 chk_all_zero("t41_rst");
    tick(); rst = 1'b0;

    // Full run with one mismatch at index 250
    do_start();
    for (int i = 0; i < NV; i++) begin
      v[i] = $urandom();
      push(v[i]);
      result((i == 250) ? (v[i] ^ 32'h00F0_0000) : v[i]);
    end
    chk("t42_done_early", 32'(bus.Done), 0);
    tick();
    chk("t42_done",  32'(bus.Done), 1);
    chk("t42_busy",  32'(bus.Busy), 0);
    chk("t42_match", 32'(bus.MatchCount), 499);
    chk("t42_mis",   32'(bus.MismatchCount), 1);
    chk("t42_idx",   32'(bus.FirstBadIndex), 250);
    result(32'hDEAD_BEEF);
    chk("t42_post_uflow", 32'(bus.Underflow), 0);
    chk("t42_post_match", 32'(bus.MatchCount), 499);

    do_start();
    chk("restart_busy",  32'(bus.Busy), 1);
    chk("restart_match", 32'(bus.MatchCount), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
